// File: rtl/conv3x3_layer_if.sv
// Frame-level bus for the 3x3 convolution layer: start/busy/done handshake
// plus the input map, weights, bias and the result map.
interface conv3x3_layer_if #(
  parameter int IN_W = 8
);
  localparam int OUT_W = IN_W - 2;

  logic               start;
  logic signed [31:0] input_fm  [0:IN_W*IN_W-1];
  logic signed [31:0] kernel    [0:8];
  logic signed [31:0] bias;
  logic               busy;
  logic               done;
  logic signed [31:0] output_fm [0:OUT_W*OUT_W-1];

  modport master (
    output start, input_fm, kernel, bias,
    input  busy, done, output_fm
  );

  modport slave (
    input  start, input_fm, kernel, bias,
    output busy, done, output_fm
  );
endinterface

// File: rtl/conv3x3_layer.sv
// 3x3 valid convolution over a square Q16.16 map with one sequential MAC.
// 11 cycles per output pixel (CLEAR, 9x MAC, WRITE); start is only honoured in IDLE/DONE.
module conv3x3_layer #(
  parameter int IN_W      = 8,
  parameter int FRAC_BITS = 16,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_layer_if.slave  bus
);
  localparam int OUT_W = IN_W - 2;
  localparam int NPIX  = OUT_W * OUT_W;
  localparam int IW    = $clog2(IN_W * IN_W);
  localparam int OW    = $clog2(NPIX);
  localparam int CW    = $clog2(IN_W);
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic signed [31:0] kern [0:8];
  logic signed [31:0] bias_q;
  logic signed [67:0] acc;
  logic [3:0]         tap;
  logic [CW-1:0]      row;
  logic [CW-1:0]      col;

  logic [1:0]         tap_r;
  logic [1:0]         tap_c;
  logic [IW-1:0]      in_idx;
  logic [OW-1:0]      out_idx;
  logic signed [31:0] pix;
  logic signed [63:0] prod;
  logic signed [67:0] shifted;
  logic signed [31:0] res;

  always_comb begin
    tap_r = 2'd0;
    tap_c = 2'd0;
    case (tap)
      4'd1: begin tap_r = 2'd0; tap_c = 2'd1; end
      4'd2: begin tap_r = 2'd0; tap_c = 2'd2; end
      4'd3: begin tap_r = 2'd1; tap_c = 2'd0; end
      4'd4: begin tap_r = 2'd1; tap_c = 2'd1; end
      4'd5: begin tap_r = 2'd1; tap_c = 2'd2; end
      4'd6: begin tap_r = 2'd2; tap_c = 2'd0; end
      4'd7: begin tap_r = 2'd2; tap_c = 2'd1; end
      4'd8: begin tap_r = 2'd2; tap_c = 2'd2; end
      default: begin tap_r = 2'd0; tap_c = 2'd0; end
    endcase
  end

  always_comb begin
    in_idx  = IW'((32'(row) + 32'(tap_r)) * 32'(IN_W) + 32'(col) + 32'(tap_c));
    out_idx = OW'(32'(row) * 32'(OUT_W) + 32'(col));
    pix     = bus.input_fm[in_idx];
    prod    = 64'(pix) * 64'(kern[tap]);
    shifted = acc >>> FRAC_BITS;
    // Saturate when bits above bit 31 are not a pure sign extension.
    if (!shifted[67] && (|shifted[66:31]))
      res = 32'sh7FFFFFFF;
    else if (shifted[67] && !(&shifted[66:31]))
      res = 32'sh80000000;
    else
      res = shifted[31:0];
    if (RELU_EN && res[31])
      res = '0;
  end

  assign bus.busy = (state == S_CLEAR) || (state == S_MAC) || (state == S_WRITE);
  assign bus.done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      bias_q <= '0;
      acc    <= '0;
      tap    <= '0;
      row    <= '0;
      col    <= '0;
      for (int i = 0; i < 9; i++) kern[i] <= '0;
      for (int i = 0; i < NPIX; i++) bus.output_fm[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            kern   <= bus.kernel;
            bias_q <= bus.bias;
            row    <= '0;
            col    <= '0;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          acc   <= $signed({{36{bias_q[31]}}, bias_q}) <<< FRAC_BITS;
          tap   <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc + $signed({{4{prod[63]}}, prod});
          tap <= tap + 4'd1;
          if (tap == 4'd8) state <= S_WRITE;
        end
        S_WRITE: begin
          bus.output_fm[out_idx] <= res;
          if (col == LAST) begin
            col <= '0;
            if (row == LAST) begin
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              state <= S_CLEAR;
            end
          end else begin
            col   <= col + 1'b1;
            state <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_layer.sv
// Directed bench: two layer instances (ReLU on / off) share one stimulus bus.
module tb_conv3x3_layer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  conv3x3_layer_if #(.IN_W(8)) bus0 ();
  conv3x3_layer_if #(.IN_W(8)) bus1 ();

  assign bus1.start    = bus0.start;
  assign bus1.input_fm = bus0.input_fm;
  assign bus1.kernel   = bus0.kernel;
  assign bus1.bias     = bus0.bias;

  conv3x3_layer #(.IN_W(8), .FRAC_BITS(16), .RELU_EN(1'b1)) u_relu (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  conv3x3_layer #(.IN_W(8), .FRAC_BITS(16), .RELU_EN(1'b0)) u_lin (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_uniform(input logic [31:0] v, input logic [31:0] k, input logic [31:0] b);
    for (int i = 0; i < 64; i++) bus0.input_fm[i] = v;
    for (int i = 0; i < 9; i++) bus0.kernel[i] = k;
    bus0.bias = b;
  endtask

  // Pulses (or holds) start, then counts cycles until done; cyc==1 is the first cycle after start.
  task automatic run_frame(input bit hold, input int change_at, input logic [31:0] new_k,
                           output int cyc, output int gaps, output bit done_at1);
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    cyc      = 1;
    gaps     = 0;
    done_at1 = bus0.done;
    if (!hold) bus0.start = 1'b0;
    while (!bus0.done && cyc < 1000) begin
      if (!bus0.busy) gaps++;
      if (cyc == change_at)
        for (int i = 0; i < 9; i++) bus0.kernel[i] = new_k;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus0.start = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    bus0.start = 1'b0;
    set_uniform(32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", bus0.busy, bus0.done);
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0 || bus1.output_fm[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got %h/%h, required 0", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_uniform();
    int cyc, gaps;
    bit d1;
    set_uniform(32'h0001_0000, 32'h0001_0000, 32'h0);
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    checks++;
    if (cyc !== 397) begin
      errors++;
      $display("FAIL uniform_latency: done after %0d cycles, required 397", cyc);
    end
    checks++;
    if (gaps !== 0 || bus0.busy !== 1'b0) begin
      errors++;
      $display("FAIL uniform_busy: %0d busy gaps, busy at done=%b, required 0 0", gaps, bus0.busy);
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0009_0000 || bus1.output_fm[i] !== 32'h0009_0000) begin
        errors++;
        $display("FAIL uniform_out[%0d]: got %h/%h, required 00090000", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
  endtask

  task automatic test_ramp();
    int cyc, gaps;
    bit d1;
    logic [31:0] exp_v;
    for (int i = 0; i < 64; i++) bus0.input_fm[i] = i << 16;
    for (int i = 0; i < 9; i++) bus0.kernel[i] = (i == 4) ? 32'h0001_0000 : 32'h0;
    bus0.bias = 32'h0000_8000;
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        exp_v = (((r + 1) * 8 + c + 1) << 16) + 32'h8000;
        checks++;
        if (bus0.output_fm[r*6+c] !== exp_v) begin
          errors++;
          $display("FAIL ramp_out[%0d][%0d]: got %h, required %h", r, c, bus0.output_fm[r*6+c], exp_v);
        end
      end
    end
  endtask

  task automatic test_relu();
    int cyc, gaps;
    bit d1;
    set_uniform(32'h0001_0000, 32'hFFFF_0000, 32'h0);
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    for (int i = 0; i < 36; i += 5) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0 || bus1.output_fm[i] !== 32'hFFF7_0000) begin
        errors++;
        $display("FAIL relu_out[%0d]: got %h/%h, required 00000000/fff70000", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int cyc, gaps;
    bit d1;
    set_uniform(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    for (int i = 0; i < 36; i += 7) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h7FFF_FFFF || bus1.output_fm[i] !== 32'h7FFF_FFFF) begin
        errors++;
        $display("FAIL sat_pos[%0d]: got %h/%h, required 7fffffff", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
    set_uniform(32'h7FFF_0000, 32'h8001_0000, 32'h0);
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    for (int i = 0; i < 36; i += 7) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0 || bus1.output_fm[i] !== 32'h8000_0000) begin
        errors++;
        $display("FAIL sat_neg[%0d]: got %h/%h, required 00000000/80000000", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int cyc, gaps;
    bit d1;
    set_uniform(32'h0001_0000, 32'h0001_0000, 32'h0);
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    repeat (199) @(posedge clk);
    #2;
    checks++;
    if (bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy=%b before reset, required 1", bus0.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: busy=%b done=%b, required 0 0", bus0.busy, bus0.done);
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0 || bus1.output_fm[i] !== 32'h0) begin
        errors++;
        $display("FAIL midreset_out[%0d]: got %h/%h, required 0", i, bus0.output_fm[i], bus1.output_fm[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_frame(1'b0, 0, 32'h0, cyc, gaps, d1);
    checks++;
    if (cyc !== 397) begin
      errors++;
      $display("FAIL after_reset_latency: done after %0d cycles, required 397", cyc);
    end
    for (int i = 0; i < 36; i += 5) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0009_0000) begin
        errors++;
        $display("FAIL after_reset_out[%0d]: got %h, required 00090000", i, bus0.output_fm[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, gaps;
    bit d1;
    set_uniform(32'h0001_0000, 32'h0001_0000, 32'h0);
    run_frame(1'b1, 0, 32'h0, cyc, gaps, d1);
    checks++;
    if (cyc !== 397 || gaps !== 0) begin
      errors++;
      $display("FAIL held_start: done after %0d cycles with %0d busy gaps, required 397 and 0", cyc, gaps);
    end
    // Second frame started from DONE; kernel is rewritten mid-frame and must not take effect.
    for (int i = 0; i < 9; i++) bus0.kernel[i] = 32'h0000_8000;
    run_frame(1'b0, 50, 32'h0002_0000, cyc, gaps, d1);
    checks++;
    if (d1 !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_drop: done=%b one cycle after start, required 0", d1);
    end
    checks++;
    if (cyc !== 397 || gaps !== 0) begin
      errors++;
      $display("FAIL restart_latency: done after %0d cycles with %0d busy gaps, required 397 and 0", cyc, gaps);
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (bus0.output_fm[i] !== 32'h0004_8000) begin
        errors++;
        $display("FAIL restart_out[%0d]: got %h, required 00048000", i, bus0.output_fm[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_uniform();
    test_ramp();
    test_relu();
    test_saturate();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
